// File: rtl/ring_pkt_pkg.sv
// ring_pkt_pkg: ring packet field map, tx FSM encoding and reply builder.
// Shared by ring_echo_responder and ring_rx_fifo users.
package ring_pkt_pkg;

   localparam int PKT_W = 64;

   localparam int VC_B  = 0;
   localparam int DIR_B = 1;
   localparam int HOP_L = 8;
   localparam int HOP_H = 15;
   localparam int SRC_L = 16;
   localparam int SRC_H = 23;
   localparam int PAY_L = 32;
   localparam int PAY_H = 63;

   localparam logic DIR_CW  = 1'b0;
   localparam logic DIR_CCW = 1'b1;

   typedef logic [0:PKT_W-1] pkt_t;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_SEND = 1'b1
   } tx_state_t;

   // Reply goes back to the source by the shorter way round; ties go cw.
   function automatic pkt_t build_reply(
      pkt_t pkt,
      int   node_id,
      int   ring_nodes
   );
      pkt_t r;
      int   src;
      int   d;
      src = int'(pkt[SRC_L:SRC_H]);
      d   = ((src % ring_nodes) - node_id + ring_nodes) % ring_nodes;
      r   = '0;
      if (d <= ring_nodes / 2) begin
         r[DIR_B]       = DIR_CW;
         r[HOP_L:HOP_H] = 8'(d);
      end else begin
         r[DIR_B]       = DIR_CCW;
         r[HOP_L:HOP_H] = 8'(ring_nodes - d);
      end
      r[SRC_L:SRC_H] = 8'(node_id);
      r[PAY_L:PAY_H] = pkt[PAY_L:PAY_H] + 32'd1;
      return r;
   endfunction

   function automatic logic [15:0] sat_inc(logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/ring_rx_fifo.sv
// ring_rx_fifo: synchronous show-ahead FIFO with full/empty flags.
// Pointers carry an extra MSB to tell full from empty.
module ring_rx_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty,
   output logic         full_nxt
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [AW:0]  wr_nxt;
   logic [AW:0]  rd_nxt;
   logic         do_push;
   logic         do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign wr_nxt = wr_ptr + (AW+1)'(do_push);
   assign rd_nxt = rd_ptr + (AW+1)'(do_pop);

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW])
               && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign full_nxt = (wr_nxt[AW] != rd_nxt[AW])
                  && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);

   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/ring_echo_responder.sv
// ring_echo_responder: ring PE-port endpoint that echoes packets to their source.
// Define ECHO_STATS_EN to add saturating rx/tx/drop counters.
module ring_echo_responder
   import ring_pkt_pkg::*;
#(
   parameter int NODE_ID    = 0,
   parameter int FIFO_DEPTH = 4,
   parameter int RING_NODES = 4
) (
   input  logic           CLK,
   input  logic           RESET,
   input  logic           polarity,
   input  logic           peso,
   output logic           pero,
   input  logic [0:PKT_W-1] pedo,
   output logic           pesi,
   input  logic           peri,
   output logic [0:PKT_W-1] pedi,
   output logic           drop_err
`ifdef ECHO_STATS_EN
  ,output logic [0:15]    rx_count
  ,output logic [0:15]    tx_count
  ,output logic [0:15]    drop_count
`endif
);

   tx_state_t state;
   tx_state_t state_d;

   pkt_t out_q;
   pkt_t fifo_q;

   logic accept;
   logic hop_zero;
   logic push;
   logic drop;
   logic pop;
   logic xfer;
   logic fifo_full;
   logic fifo_empty;
   logic fifo_full_nxt;

   assign accept   = peso && pero;
   assign hop_zero = (pedo[HOP_L:HOP_H] == 8'd0);
   assign push     = accept && hop_zero && !fifo_full;
   assign drop     = accept && !hop_zero;

   ring_rx_fifo #(
      .W     (PKT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (CLK),
      .rst_n    (RESET),
      .push     (push),
      .wdata    (pedo),
      .pop      (pop),
      .rdata    (fifo_q),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .full_nxt (fifo_full_nxt)
   );

   // Replies may only be offered in the vc-0 phase of the router.
   assign pesi = (state == TX_SEND) && !polarity;
   assign xfer = pesi && peri;

   assign pedi = (state == TX_SEND)
               ? {polarity, out_q[1:PKT_W-1]}
               : out_q;

   always_comb begin
      state_d = state;
      pop     = 1'b0;
      unique case (state)
         TX_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = TX_SEND;
            end
         end
         TX_SEND: begin
            if (xfer) begin
               if (!fifo_empty) begin
                  pop = 1'b1;
               end else begin
                  state_d = TX_IDLE;
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state    <= TX_IDLE;
         out_q    <= '0;
         pero     <= 1'b0;
         drop_err <= 1'b0;
      end else begin
         state    <= state_d;
         pero     <= !fifo_full_nxt;
         drop_err <= drop;
         if (pop) begin
            out_q <= build_reply(fifo_q, NODE_ID, RING_NODES);
         end
      end
   end

`ifdef ECHO_STATS_EN
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         rx_count   <= '0;
         tx_count   <= '0;
         drop_count <= '0;
      end else begin
         if (accept) begin
            rx_count <= sat_inc(rx_count);
         end
         if (xfer) begin
            tx_count <= sat_inc(tx_count);
         end
         if (drop) begin
            drop_count <= sat_inc(drop_count);
         end
      end
   end
`endif

endmodule

// File: tb/tb_ring_echo_responder.sv
// tb_ring_echo_responder: directed + randomized bench with a queue model.
// Build with ECHO_STATS_EN to also check the counters.
module tb_ring_echo_responder;

   localparam int NODE_ID    = 0;
   localparam int FIFO_DEPTH = 4;
   localparam int RING       = 4;

   typedef logic [0:63] pkt_t;

   logic CLK      = 1'b0;
   logic RESET    = 1'b0;
   logic polarity = 1'b0;
   logic peso     = 1'b0;
   logic peri     = 1'b0;
   pkt_t pedo     = '0;
   logic pero;
   logic pesi;
   logic drop_err;
   pkt_t pedi;
`ifdef ECHO_STATS_EN
   logic [0:15] rx_count;
   logic [0:15] tx_count;
   logic [0:15] drop_count;
`endif

   ring_echo_responder #(
      .NODE_ID    (NODE_ID),
      .FIFO_DEPTH (FIFO_DEPTH),
      .RING_NODES (RING)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .polarity (polarity),
      .peso     (peso),
      .pero     (pero),
      .pedo     (pedo),
      .pesi     (pesi),
      .peri     (peri),
      .pedi     (pedi),
      .drop_err (drop_err)
`ifdef ECHO_STATS_EN
     ,.rx_count   (rx_count)
     ,.tx_count   (tx_count)
     ,.drop_count (drop_count)
`endif
   );

   always #5 CLK = ~CLK;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   mon_en   = 0;

   // behavioural model state
   pkt_t mq[$];
   bit   has_out = 0;
   pkt_t out_pkt = '0;
   bit   m_pero  = 0;
   bit   m_drop  = 0;
   int   m_rx    = 0;
   int   m_tx    = 0;
   int   m_dr    = 0;

   pkt_t tx_seen[$];
   int   first_tx_cyc = -1;

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
      polarity = ~polarity;
      cyc++;
      #1;
   endtask

   function automatic pkt_t mk(input logic [7:0] src,
                               input logic [7:0] hop,
                               input logic [31:0] pay);
      return {2'b00, 6'b0, hop, src, 8'h00, pay};
   endfunction

   function automatic pkt_t model_reply(input pkt_t p);
      int s;
      int d;
      int steps;
      bit ccw;
      logic [31:0] pay;
      s     = int'(p[16:23]);
      d     = ((s % RING) - NODE_ID + RING) % RING;
      ccw   = (d > RING / 2);
      steps = ccw ? RING - d : d;
      pay   = p[32:63] + 32'd1;
      return {1'b0, ccw, 6'b0, 8'(steps), 8'(NODE_ID), 8'h00, pay};
   endfunction

   // compare + model advance, once per cycle, after inputs settle
   always @(negedge CLK) begin
      bit   acc;
      bit   hz;
      bit   sent;
      pkt_t p;
      #2;
      if (mon_en) begin
         chk("pero", pero, 64'(m_pero));
         chk("pesi", pesi, 64'(has_out && !polarity));
         chk("drop_err", drop_err, 64'(m_drop));
         if (has_out && !polarity) begin
            chk("pedi", pedi, {1'b0, out_pkt[1:63]});
         end
`ifdef ECHO_STATS_EN
         chk("rx_count", rx_count, 64'(m_rx));
         chk("tx_count", tx_count, 64'(m_tx));
         chk("drop_count", drop_count, 64'(m_dr));
`endif
      end
      if (pesi === 1'b1 && peri) begin
         if (tx_seen.size() == 0) first_tx_cyc = cyc;
         tx_seen.push_back(pedi);
      end
      if (!RESET) begin
         mq.delete();
         has_out = 0;
         out_pkt = '0;
         m_pero  = 0;
         m_drop  = 0;
         m_rx    = 0;
         m_tx    = 0;
         m_dr    = 0;
      end else begin
         acc  = peso && m_pero;
         hz   = (pedo[8:15] == 8'd0);
         sent = has_out && !polarity && peri;
         if (sent) begin
            has_out = 0;
            m_tx++;
         end
         if (!has_out && mq.size() > 0) begin
            p       = mq.pop_front();
            out_pkt = model_reply(p);
            has_out = 1;
         end
         if (acc && hz) mq.push_back(pedo);
         if (acc) m_rx++;
         if (acc && !hz) m_dr++;
         m_drop = acc && !hz;
         m_pero = (mq.size() < FIFO_DEPTH);
      end
   end

   task automatic send_one(input logic [7:0] src,
                           input logic [7:0] hop,
                           input logic [31:0] pay,
                           output pkt_t rep,
                           output int lat,
                           output bit p0,
                           output bit got);
      int n;
      int t0;
      tx_seen.delete();
      got = 0;
      rep = '0;
      lat = -1;
      p0  = 0;
      n   = 0;
      while (pero !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("pero_ready", pero, 64'd1);
      peso = 1'b1;
      pedo = mk(src, hop, pay);
      t0   = cyc;
      p0   = polarity;
      tick();
      peso = 1'b0;
      pedo = '0;
      n    = 0;
      while (tx_seen.size() == 0 && n < 20) begin
         tick();
         n++;
      end
      if (tx_seen.size() > 0) begin
         got = 1;
         rep = tx_seen[0];
         lat = first_tx_cyc - t0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      pkt_t rep;
      pkt_t hold;
      pkt_t t;
      int   lat;
      bit   p0;
      bit   got;
      int   acc;
      int   n;
      logic [31:0] accpay[$];

      RESET = 1'b0;
      tick();
      tick();
      mon_en = 1;
      tick();
      chk("rst_pero", pero, 64'd0);
      chk("rst_pesi", pesi, 64'd0);
      chk("rst_pedi", pedi, 64'd0);
      chk("rst_drop", drop_err, 64'd0);
      RESET = 1'b1;
      tick();
      chk("rel_pero", pero, 64'd1);
      peri = 1'b1;

      send_one(8'd1, 8'd0, 32'h5, rep, lat, p0, got);
      chk("got_src1", 64'(got), 64'd1);
      chk("rep_src1", rep, 64'h0001_0000_0000_0006);
      chk("lat_src1", 64'(lat), p0 ? 64'd3 : 64'd2);

      send_one(8'd3, 8'd0, 32'h10, rep, lat, p0, got);
      chk("rep_src3", rep, 64'h4001_0000_0000_0011);
      chk("lat_src3", 64'(lat), p0 ? 64'd3 : 64'd2);

      send_one(8'd2, 8'd0, 32'h20, rep, lat, p0, got);
      chk("rep_src2", rep, 64'h0002_0000_0000_0021);

      send_one(8'd0, 8'd0, 32'h30, rep, lat, p0, got);
      chk("rep_src0", rep, 64'h0000_0000_0000_0031);

      send_one(8'd1, 8'd0, 32'hFFFF_FFFF, rep, lat, p0, got);
      chk("rep_wrap", rep, 64'h0001_0000_0000_0000);

      // nonzero hop: dropped with a one-cycle pulse, nothing echoed
      tx_seen.delete();
      tick();
      peso = 1'b1;
      pedo = mk(8'd1, 8'h01, 32'h7);
      tick();
      peso = 1'b0;
      chk("drop_pulse", drop_err, 64'd1);
      tick();
      chk("drop_clear", drop_err, 64'd0);
      repeat (10) tick();
      chk("drop_no_tx", 64'(tx_seen.size()), 64'd0);

      // backpressure: FIFO plus the held reply fill up
      tx_seen.delete();
      peri = 1'b0;
      acc  = 0;
      for (int i = 0; i < FIFO_DEPTH + 4; i++) begin
         peso = 1'b1;
         pedo = mk(8'd1, 8'd0, 32'h100 + 32'(i));
         if (pero === 1'b1) begin
            acc++;
            accpay.push_back(32'h100 + 32'(i));
         end
         tick();
      end
      peso = 1'b0;
      chk("full_pero", pero, 64'd0);
      chk("full_acc", 64'(acc), 64'(FIFO_DEPTH + 1));
      hold = pedi;
      repeat (6) tick();
      chk("pedi_stable", 64'(pedi[1:63]), 64'(hold[1:63]));
      peri = 1'b1;
      repeat (24) tick();
      chk("drain_cnt", 64'(tx_seen.size()), 64'(acc));
      n = (tx_seen.size() < accpay.size()) ? tx_seen.size() : accpay.size();
      for (int k = 0; k < n; k++) begin
         t = tx_seen[k];
         chk("drain_order", 64'(t[32:63]), 64'(accpay[k] + 32'd1));
      end

      // reset while a reply is being offered
      tx_seen.delete();
      peri = 1'b0;
      tick();
      peso = 1'b1;
      pedo = mk(8'd2, 8'd0, 32'h55);
      tick();
      peso = 1'b0;
      n = 0;
      while (pesi !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("pre_rst_pesi", pesi, 64'd1);
      RESET = 1'b0;
      tick();
      chk("mid_rst_pesi", pesi, 64'd0);
      chk("mid_rst_pero", pero, 64'd0);
      tick();
      chk("mid_rst_pesi2", pesi, 64'd0);
      RESET = 1'b1;
      tick();
      chk("post_rst_pero", pero, 64'd1);
      peri = 1'b1;
      repeat (10) tick();
      chk("post_rst_no_tx", 64'(tx_seen.size()), 64'd0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         peso = 1'($urandom % 2);
         pedo = mk(8'($urandom % RING),
                   ($urandom % 8 == 0) ? 8'($urandom_range(1, 255)) : 8'd0,
                   $urandom);
         peri  = 1'(($urandom % 4) != 0);
         RESET = 1'(($urandom % 400) != 0);
         tick();
      end
      RESET = 1'b1;
      peso  = 1'b0;
      peri  = 1'b1;
      repeat (30) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
